// File: rtl/quiz_control_param.sv
// Game-sequencing controller for the fastest-finger quiz: steps through the
// questions, gates per-player time-register loads and drives VGA control.
module quiz_control_param #(
   parameter int NUM_PLAYERS    = 3,
   parameter int NUM_QUESTIONS  = 5,
   parameter int QSEL_W         = 3,
   parameter int TMO_W          = 26,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 gamestart,
   input  logic                                 displayrankings,
   input  logic [NUM_PLAYERS-1:0]               ans_valid,
   output logic [NUM_PLAYERS*NUM_QUESTIONS-1:0] ld_player,
   output logic [QSEL_W-1:0]                    question_selection,
   output logic                                 cctenable,
   output logic                                 ld_game,
   output logic                                 ld_r,
   output logic                                 endgame,
   output logic                                 go,
   output logic                                 rankdisplay,
   output logic [NUM_PLAYERS-1:0]               answered,
   output logic                                 timeout,
   output logic [1:0]                           state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ASK  = 2'd1,
      S_WAIT = 2'd2,
      S_RANK = 2'd3
   } state_t;

   localparam logic [QSEL_W-1:0]      LAST_Q   = QSEL_W'(NUM_QUESTIONS - 1);
   localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam bit                     TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [NUM_PLAYERS-1:0] ALL_ANS  = '1;

   state_t                  state, state_n;
   logic [QSEL_W-1:0]       qidx, qidx_n;
   logic [NUM_PLAYERS-1:0]  ans_q, ans_n, ans_all;
   logic [TMO_W-1:0]        tmo_cnt, tmo_n;
   logic                    gs_q;
   logic                    timeout_q, timeout_n;
   logic                    tmo_hit;
   logic                    gs_rise;

   assign gs_rise = gamestart & ~gs_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         qidx      <= '0;
         ans_q     <= '0;
         tmo_cnt   <= '0;
         gs_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_n;
         qidx      <= qidx_n;
         ans_q     <= ans_n;
         tmo_cnt   <= tmo_n;
         gs_q      <= gamestart;
         timeout_q <= timeout_n;
      end
   end

   // Next-state logic; answers are only latched while a question is open.
   always_comb begin
      state_n   = state;
      qidx_n    = qidx;
      ans_n     = ans_q;
      tmo_n     = tmo_cnt;
      timeout_n = 1'b0;
      ans_all   = ans_q | ans_valid;
      tmo_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (gs_rise) begin
               state_n = S_ASK;
               qidx_n  = '0;
               ans_n   = '0;
               tmo_n   = '0;
            end
         end
         S_ASK: begin
            ans_n = ans_all;
            if (TMO_EN) begin
               tmo_n   = tmo_cnt + 1'b1;
               tmo_hit = (tmo_cnt == TMO_LAST);
            end
            timeout_n = tmo_hit;
            if (!gamestart || (ans_all == ALL_ANS) || tmo_hit) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            // Only a fresh edge advances, so an early close with the switch still up holds here.
            if (gs_rise) begin
               if (qidx == LAST_Q) begin
                  state_n = S_RANK;
               end else begin
                  state_n = S_ASK;
                  qidx_n  = qidx + 1'b1;
                  ans_n   = '0;
                  tmo_n   = '0;
               end
            end
         end
         S_RANK: begin
            if (!displayrankings) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Moore output decode from registered state only.
   always_comb begin
      ld_player          = '0;
      question_selection = '1;
      cctenable          = 1'b0;
      ld_game            = 1'b0;
      ld_r               = 1'b0;
      endgame            = 1'b0;
      go                 = 1'b0;
      rankdisplay        = 1'b0;
      answered           = '0;
      case (state)
         S_IDLE: begin
            ld_game = 1'b1;
            ld_r    = 1'b1;
         end
         S_ASK: begin
            question_selection = qidx;
            cctenable          = 1'b1;
            go                 = ~qidx[0];
            answered           = ans_q;
            for (int q = 0; q < NUM_QUESTIONS; q++) begin
               for (int p = 0; p < NUM_PLAYERS; p++) begin
                  ld_player[q*NUM_PLAYERS+p] = (qidx == QSEL_W'(q)) & ~ans_q[p];
               end
            end
         end
         S_WAIT: begin
            question_selection = qidx;
            ld_game            = 1'b1;
            go                 = ~qidx[0];
            answered           = ans_q;
         end
         S_RANK: begin
            endgame     = 1'b1;
            ld_r        = 1'b1;
            rankdisplay = 1'b1;
         end
         default: begin
            ld_game = 1'b1;
            ld_r    = 1'b1;
         end
      endcase
   end

   assign timeout   = timeout_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_quiz_control_param.sv
// Directed bench for quiz_control_param: a default 3x5 instance and a 4x6
// instance with an 8-cycle question timeout, checked through a scoreboard.
module tb_quiz_control_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b0, gs_a = 1'b0, dr_a = 1'b0;
   logic [2:0]  av_a = '0;
   logic        rst_b = 1'b0, gs_b = 1'b0, dr_b = 1'b0;
   logic [3:0]  av_b = '0;

   logic [14:0] ldp_a;
   logic [2:0]  qs_a, ans_a;
   logic        cct_a, ldg_a, ldr_a, eg_a, go_a, rd_a, to_a;
   logic [1:0]  st_a;
   logic [23:0] ldp_b;
   logic [2:0]  qs_b;
   logic [3:0]  ans_b;
   logic        cct_b, ldg_b, ldr_b, eg_b, go_b, rd_b, to_b;
   logic [1:0]  st_b;

   quiz_control_param #(.NUM_PLAYERS(3), .NUM_QUESTIONS(5), .QSEL_W(3),
                        .TMO_W(26), .TIMEOUT_CYCLES(0)) dut_a (
      .clk(clk), .reset(rst_a), .gamestart(gs_a), .displayrankings(dr_a),
      .ans_valid(av_a), .ld_player(ldp_a), .question_selection(qs_a),
      .cctenable(cct_a), .ld_game(ldg_a), .ld_r(ldr_a), .endgame(eg_a),
      .go(go_a), .rankdisplay(rd_a), .answered(ans_a), .timeout(to_a),
      .state_dbg(st_a)
   );

   quiz_control_param #(.NUM_PLAYERS(4), .NUM_QUESTIONS(6), .QSEL_W(3),
                        .TMO_W(26), .TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .reset(rst_b), .gamestart(gs_b), .displayrankings(dr_b),
      .ans_valid(av_b), .ld_player(ldp_b), .question_selection(qs_b),
      .cctenable(cct_b), .ld_game(ldg_b), .ld_r(ldr_b), .endgame(eg_b),
      .go(go_b), .rankdisplay(rd_b), .answered(ans_b), .timeout(to_b),
      .state_dbg(st_b)
   );

   // Observation word: {ld_player, qsel, cct, ld_game, ld_r, endgame, go, rank, answered, timeout, state}
   logic [39:0] obs_a, obs_b;
   assign obs_a = {9'd0, ldp_a, qs_a, cct_a, ldg_a, ldr_a, eg_a, go_a, rd_a,
                   1'b0, ans_a, to_a, st_a};
   assign obs_b = {ldp_b, qs_b, cct_b, ldg_b, ldr_b, eg_b, go_b, rd_b,
                   ans_b, to_b, st_b};

   logic [40:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   event        sample_ev;

   function automatic logic [39:0] pack(input logic [23:0] ldp, input logic [2:0] qsel,
                                        input logic cct, ldg, ldr, eg, g, rd,
                                        input logic [3:0] ans, input logic tmo,
                                        input logic [1:0] st);
      return {ldp, qsel, cct, ldg, ldr, eg, g, rd, ans, tmo, st};
   endfunction

   function automatic logic [39:0] e_idle();
      return pack(24'd0, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0);
   endfunction

   function automatic logic [39:0] e_rank();
      return pack(24'd0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'd3);
   endfunction

   function automatic logic [39:0] e_ask(input int np, input int q, input logic [3:0] ans);
      logic [23:0] mask;
      logic [23:0] ldp;
      logic [2:0]  qs;
      mask = (np == 3) ? 24'h7 : 24'hF;
      ldp  = (~{20'd0, ans} & mask) << (q * np);
      qs   = 3'(q);
      return pack(ldp, qs, 1'b1, 1'b0, 1'b0, 1'b0, ~qs[0], 1'b0, ans, 1'b0, 2'd1);
   endfunction

   function automatic logic [39:0] e_wait(input int q, input logic [3:0] ans, input logic tmo);
      logic [2:0] qs;
      qs = 3'(q);
      return pack(24'd0, qs, 1'b0, 1'b1, 1'b0, 1'b0, ~qs[0], 1'b0, ans, tmo, 2'd2);
   endfunction

   // Drive one cycle of inputs to the selected DUT and queue the post-edge expectation.
   task automatic step(input bit sel, input logic gs, input logic dr,
                       input logic [3:0] av, input logic rst, input logic [39:0] e);
      if (!sel) begin
         gs_a = gs; dr_a = dr; av_a = av[2:0]; rst_a = rst;
      end else begin
         gs_b = gs; dr_b = dr; av_b = av; rst_b = rst;
      end
      @(posedge clk);
      exp_q.push_back({sel, e});
      #1;
   endtask

   task automatic check_now(input bit sel, input logic [39:0] e);
      exp_q.push_back({sel, e});
      ->sample_ev;
      #1;
   endtask

   // Monitor: compares each queued expectation against the addressed DUT.
   initial begin
      logic [40:0] x;
      logic [39:0] got;
      forever begin
         @(negedge clk or sample_ev);
         if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            got = x[40] ? obs_b : obs_a;
            n_vec++;
            if (got !== x[39:0]) begin
               n_err++;
               $display("FAIL vec%0d dut_%s: got %h expected %h", n_vec,
                        x[40] ? "b" : "a", got, x[39:0]);
            end
         end
      end
   end

   initial begin
      #2;
      check_now(1'b0, e_idle());
      check_now(1'b1, e_idle());
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_idle());
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_idle());
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_idle());

      // Full default game, then rankings held for 20 cycles.
      for (int q = 0; q < 5; q++) begin
         step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, e_ask(3, q, 4'd0));
         step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, e_wait(q, 4'd0, 1'b0));
      end
      step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, e_rank());
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, e_rank());
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, e_idle());
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_idle());

      // Answer lock-out and early close with the switch still up.
      step(1'b0, 1'b1, 1'b0, 4'd0,    1'b1, e_ask(3, 0, 4'd0));
      step(1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, e_ask(3, 0, 4'b0010));
      step(1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, e_wait(0, 4'b0111, 1'b0));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b0111, 1'b1, e_wait(0, 4'b0111, 1'b0));
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_wait(0, 4'b0111, 1'b0));
      for (int q = 1; q < 3; q++) begin
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, e_ask(3, q, 4'd0));
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_wait(q, 4'd0, 1'b0));
      end
      step(1'b0, 1'b1, 1'b0, 4'd0,    1'b1, e_ask(3, 3, 4'd0));
      step(1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, e_ask(3, 3, 4'b0001));

      // Asynchronous reset mid-question, then a fresh game from q=0.
      @(negedge clk);
      #1;
      rst_a = 1'b0;
      #1;
      check_now(1'b0, e_idle());
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, e_idle());
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, e_ask(3, 0, 4'd0));
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_wait(0, 4'd0, 1'b0));

      // 4-player/6-question instance: timeout on q0, lock-out on q1, full mapping.
      step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, e_ask(4, 0, 4'd0));
      for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, e_ask(4, 0, 4'd0));
      step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, e_wait(0, 4'd0, 1'b1));
      step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, e_wait(0, 4'd0, 1'b0));
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_wait(0, 4'd0, 1'b0));
      step(1'b1, 1'b1, 1'b0, 4'd0,    1'b1, e_ask(4, 1, 4'd0));
      step(1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, e_ask(4, 1, 4'b1000));
      step(1'b1, 1'b0, 1'b0, 4'd0,    1'b1, e_wait(1, 4'b1000, 1'b0));
      for (int q = 2; q < 6; q++) begin
         step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, e_ask(4, q, 4'd0));
         step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_wait(q, 4'd0, 1'b0));
      end
      step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, e_rank());
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_idle());

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
